loop_filter_gear_ctrl: RTL and testbench
========================================

// Module: loop_filter_gear_ctrl
// PURPOSE
//  Gear-shifting controller for the PLL digital loop filter. Turns phase-detector up/down pulses
//  into carry/borrow pulses for the increment/decrement stage through a symmetric K counter.
//  The counter modulus switches between wide-band ACQUIRE (K_ACQ) and narrow-band TRACK (K_TRK).
//  Gear selection comes from a windowed lock detector on the carry/borrow rate.
// PARAMETERS
//  CNT_W         8   signed K-counter width; 2^(CNT_W-1)-1 must be >= K_TRK
//  K_ACQ         8   modulus in ACQUIRE (carry at +K_ACQ, borrow at -K_ACQ)
//  K_TRK         32  modulus in TRACK
//  WIN_W         10  lock window = 2^WIN_W clocks
//  EV_W          6   event-counter width (saturating)
//  LOCK_THRESH   2   window events <= this counts as a quiet window
//  UNLOCK_THRESH 8   window events > this while in TRACK means loss of lock
//  LOCK_WINDOWS  4   consecutive quiet windows required to enter TRACK
// PORTS
//  clk_i       in   1        system clock
//  reset_i     in   1        asynchronous, active-low reset
//  enable_i    in   1        loop enable; low forces IDLE
//  up_i        in   1        phase detector: VCO lags (increment)
//  down_i      in   1        phase detector: VCO leads (decrement)
//  carry_o     out  1        one-cycle pulse: counter hit +K
//  borrow_o    out  1        one-cycle pulse: counter hit -K
//  mode_o      out  2        current mode_e (IDLE=0, ACQUIRE=1, TRACK=2)
//  locked_o    out  1        high while in TRACK
// BEHAVIOUR
//  Reset (reset_i=0, async): mode=IDLE, cnt=0, window/event/streak counters=0; all outputs 0.
//  Counter step per clock: up_i & !down_i -> cnt+1; down_i & !up_i -> cnt-1; both or neither -> hold.
//  Terminal detection: carry_o = (cnt == +K), borrow_o = (cnt == -K), with K taken from the current
//    mode. Decoded combinationally from the cnt register, so carry_o/borrow_o rise the cycle after
//    the step that reached K.
//  In a terminal cycle cnt reloads to 0 and up_i/down_i are ignored.
//  FSM:
//   IDLE    : enable_i=1 -> ACQUIRE (next cycle).
//   ACQUIRE : K=K_ACQ; quiet-window streak reaches LOCK_WINDOWS -> TRACK.
//   TRACK   : K=K_TRK; window with events > UNLOCK_THRESH -> ACQUIRE.
//   Any state: enable_i=0 -> IDLE next cycle; cnt, window, event and streak counters cleared.
//  On every mode transition cnt reloads to 0 and the streak clears. This keeps |cnt| <= K after a
//    TRACK->ACQUIRE shrink.
//  Window: free-running WIN_W counter, runs only in ACQUIRE/TRACK, restarts at 0 on mode entry.
//   Each carry_o|borrow_o cycle increments evCnt, saturating at 2^EV_W-1.
//   At window end (winCnt = all ones), evaluate evTot = evCnt plus the event in that cycle, then
//     clear evCnt to 0.
//   ACQUIRE: evTot <= LOCK_THRESH -> streak+1, else streak=0; mode changes in the cycle after
//     streak reaches LOCK_WINDOWS.
//   TRACK: evTot > UNLOCK_THRESH -> ACQUIRE next cycle.
//  locked_o = (mode==TRACK), registered with the mode; mode_o = mode register.
//  Reset mid-operation: immediate return to the reset state; no pulse completes.
//  Width rule: all cnt compares are signed CNT_W; K constants are sign-extended.
// STRUCTURE
//  pll_pkg: typedef enum logic [1:0] mode_e {IDLE, ACQUIRE, TRACK}; shared with the other loop-filter blocks.
//  Sub-module kcounter_var: CNT_W signed up/down counter.
//   Inputs: modulus k_i, clear_i. Outputs: carry_o, borrow_o.
//   Owns the step, terminal and reload rules.
//  Top level holds the FSM, window counter, event counter and streak logic.
// TESTING
//  1 Reset, enable=1, up_i held high 9 clocks -> mode=ACQUIRE; carry_o pulses on cycle 9
//    (cnt reached 8 on the 8th up); cnt=0 after.
//  2 up_i & down_i both high 50 clocks -> cnt unchanged; no carry_o/borrow_o.
//  3 Enable with no up/down for 4 windows (4*1024 clocks) -> TRACK at window-4 end +1; locked_o=1.
//  4 In TRACK, 9 carries within one window -> ACQUIRE after that window; cnt=0; locked_o=0.
//  5 In TRACK with cnt=+20, drop enable_i -> IDLE next cycle, cnt=0; re-enable -> ACQUIRE,
//    first carry after 8 ups.
//  6 Assert reset_i=0 asynchronously mid-window with carry pending -> all outputs 0 immediately.

Source files
------------

// File: rtl/pll_pkg.sv
// ----------------------------------------------------------------------------
// pll_pkg
//   Shared types for the PLL digital loop-filter blocks.
//   mode_e : loop-filter gear (IDLE / wide-band ACQUIRE / narrow-band TRACK).
// ----------------------------------------------------------------------------
package pll_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } mode_e;

    // True for the modes in which the loop filter is actually running.
    function automatic logic mode_is_active(input mode_e m);
        return (m == ACQUIRE) || (m == TRACK);
    endfunction

endpackage

// File: rtl/loop_filter_gear_ctrl_kcounter_var.sv
// ----------------------------------------------------------------------------
// kcounter_var
//   Signed symmetric K counter with a run-time modulus.
//   Ports:
//     clk_i     in  clock
//     reset_i   in  asynchronous active-low reset
//     up_i      in  count up request
//     down_i    in  count down request
//     clear_i   in  synchronous reload of the counter to 0
//     k_i       in  modulus (signed CNT_W, positive)
//     carry_o   out high while the counter sits at +K
//     borrow_o  out high while the counter sits at -K
//   The terminal flags are decoded from the count register, so a pulse
//   appears the cycle after the step that reached +/-K; during that cycle the
//   counter reloads to 0 and ignores up_i/down_i.
// ----------------------------------------------------------------------------
module kcounter_var #(
    parameter int CNT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    up_i,
    input  logic                    down_i,
    input  logic                    clear_i,
    input  logic signed [CNT_W-1:0] k_i,
    output logic                    carry_o,
    output logic                    borrow_o
);

    logic signed [CNT_W-1:0] cnt_reg;
    logic signed [CNT_W-1:0] cnt_next;
    logic signed [CNT_W-1:0] neg_k;

    assign neg_k    = -k_i;
    assign carry_o  = (cnt_reg == k_i);
    assign borrow_o = (cnt_reg == neg_k);

    always_comb begin
        cnt_next = cnt_reg;
        if (clear_i || carry_o || borrow_o) begin
            cnt_next = '0;
        end else if (up_i && !down_i) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end else if (down_i && !up_i) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/loop_filter_gear_ctrl.sv
// ----------------------------------------------------------------------------
// loop_filter_gear_ctrl
//   Gear-shifting controller for the PLL digital loop filter. Converts
//   phase-detector up/down requests into carry/borrow pulses through a K
//   counter whose modulus follows the gear: K_ACQ in ACQUIRE, K_TRK in TRACK.
//   A windowed lock detector on the carry/borrow rate selects the gear.
//   Ports:
//     clk_i     in  clock
//     reset_i   in  asynchronous active-low reset
//     enable_i  in  loop enable; low forces IDLE
//     up_i      in  VCO lags (increment)
//     down_i    in  VCO leads (decrement)
//     carry_o   out one-cycle pulse, counter hit +K
//     borrow_o  out one-cycle pulse, counter hit -K
//     mode_o    out current mode_e
//     locked_o  out high while in TRACK
// ----------------------------------------------------------------------------
module loop_filter_gear_ctrl
    import pll_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int K_ACQ         = 8,
    parameter int K_TRK         = 32,
    parameter int WIN_W         = 10,
    parameter int EV_W          = 6,
    parameter int LOCK_THRESH   = 2,
    parameter int UNLOCK_THRESH = 8,
    parameter int LOCK_WINDOWS  = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       up_i,
    input  logic       down_i,
    output logic       carry_o,
    output logic       borrow_o,
    output logic [1:0] mode_o,
    output logic       locked_o
);

    localparam int STREAK_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic signed [CNT_W-1:0] K_ACQ_S       = CNT_W'(K_ACQ);
    localparam logic signed [CNT_W-1:0] K_TRK_S       = CNT_W'(K_TRK);
    localparam logic [EV_W:0]           LOCK_LIMIT    = (EV_W+1)'(LOCK_THRESH);
    localparam logic [EV_W:0]           UNLOCK_LIMIT  = (EV_W+1)'(UNLOCK_THRESH);
    localparam logic [STREAK_W-1:0]     STREAK_TARGET = STREAK_W'(LOCK_WINDOWS);

    mode_e                   mode_reg;
    mode_e                   mode_next;
    logic [WIN_W-1:0]        win_reg;
    logic [WIN_W-1:0]        win_next;
    logic [EV_W-1:0]         ev_reg;
    logic [EV_W-1:0]         ev_next;
    logic [STREAK_W-1:0]     streak_reg;
    logic [STREAK_W-1:0]     streak_next;
    logic                    locked_reg;

    logic                    active;
    logic                    win_end;
    logic                    mode_change;
    logic                    cnt_clear;
    logic                    event_pulse;
    logic                    quiet_window;
    logic                    loud_window;
    logic [EV_W:0]           ev_tot;
    logic signed [CNT_W-1:0] k_sel;

    // ------------------------------------------------------------------
    // K counter
    // ------------------------------------------------------------------
    assign k_sel = (mode_reg == TRACK) ? K_TRK_S : K_ACQ_S;

    // The counter is held at 0 outside the running modes and reloaded on
    // every gear change, so |cnt| never exceeds a freshly shrunk K.
    assign cnt_clear = mode_change || !active;

    kcounter_var #(
        .CNT_W (CNT_W)
    ) u_kcnt (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .up_i     (up_i),
        .down_i   (down_i),
        .clear_i  (cnt_clear),
        .k_i      (k_sel),
        .carry_o  (carry_o),
        .borrow_o (borrow_o)
    );

    // ------------------------------------------------------------------
    // Lock detector
    // ------------------------------------------------------------------
    assign active      = mode_is_active(mode_reg);
    assign win_end     = active && (&win_reg);
    assign event_pulse = carry_o || borrow_o;

    // Window total includes the event landing in the final window cycle;
    // one extra bit so a saturated count plus that event cannot wrap.
    assign ev_tot       = {1'b0, ev_reg} + (EV_W+1)'(event_pulse);
    assign quiet_window = (ev_tot <= LOCK_LIMIT);
    assign loud_window  = (ev_tot > UNLOCK_LIMIT);

    // ------------------------------------------------------------------
    // Mode FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        mode_next = mode_reg;
        if (!enable_i) begin
            mode_next = IDLE;
        end else begin
            case (mode_reg)
                IDLE:    mode_next = ACQUIRE;
                ACQUIRE: if (streak_reg == STREAK_TARGET) mode_next = TRACK;
                TRACK:   if (win_end && loud_window)      mode_next = ACQUIRE;
                default: mode_next = IDLE;
            endcase
        end
    end

    assign mode_change = (mode_next != mode_reg);

    // ------------------------------------------------------------------
    // Window, event and streak counters
    // ------------------------------------------------------------------
    always_comb begin
        win_next    = win_reg + WIN_W'(1);
        ev_next     = ev_reg;
        streak_next = streak_reg;

        if (mode_change || !active) begin
            // Window restarts from 0 on mode entry; IDLE keeps everything clear.
            win_next    = '0;
            ev_next     = '0;
            streak_next = '0;
        end else begin
            if (win_end) begin
                ev_next = '0;
            end else if (event_pulse && !(&ev_reg)) begin
                ev_next = ev_reg + EV_W'(1);
            end

            if (win_end && (mode_reg == ACQUIRE)) begin
                if (!quiet_window) begin
                    streak_next = '0;
                end else if (streak_reg != STREAK_TARGET) begin
                    streak_next = streak_reg + STREAK_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mode_reg   <= IDLE;
            win_reg    <= '0;
            ev_reg     <= '0;
            streak_reg <= '0;
            locked_reg <= 1'b0;
        end else begin
            mode_reg   <= mode_next;
            win_reg    <= win_next;
            ev_reg     <= ev_next;
            streak_reg <= streak_next;
            locked_reg <= (mode_next == TRACK);
        end
    end

    assign mode_o   = mode_reg;
    assign locked_o = locked_reg;

endmodule

// File: tb/tb_loop_filter_gear_ctrl.sv
// ----------------------------------------------------------------------------
// tb_loop_filter_gear_ctrl
//   Directed test of the gear-shifting loop-filter controller with
//   hand-computed expectations (default parameters: K_ACQ=8, K_TRK=32,
//   1024-clock window, lock after 4 quiet windows, unlock above 8 events).
// ----------------------------------------------------------------------------
module tb_loop_filter_gear_ctrl;

    logic       clk_i;
    logic       reset_i;
    logic       enable_i;
    logic       up_i;
    logic       down_i;
    logic       carry_o;
    logic       borrow_o;
    logic [1:0] mode_o;
    logic       locked_o;

    int total;
    int bad;

    localparam int M_IDLE = 0;
    localparam int M_ACQ  = 1;
    localparam int M_TRK  = 2;

    loop_filter_gear_ctrl dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .up_i     (up_i),
        .down_i   (down_i),
        .carry_o  (carry_o),
        .borrow_o (borrow_o),
        .mode_o   (mode_o),
        .locked_o (locked_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Every DUT output is sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance n clocks, counting carry and borrow pulses seen.
    task automatic run_count(input int n, output int carries, output int borrows);
        carries = 0;
        borrows = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (carry_o === 1'b1)  carries++;
            if (borrow_o === 1'b1) borrows++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            $display("check %s obs=%0d exp=%0d ok", tag, obs, exp);
        end else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int b;
        total    = 0;
        bad      = 0;
        reset_i  = 1'b0;
        enable_i = 1'b0;
        up_i     = 1'b0;
        down_i   = 1'b0;

        // ---------------- reset state ----------------
        #12;
        chk("rst_mode",   32'(mode_o),   M_IDLE);
        chk("rst_locked", 32'(locked_o), 0);
        chk("rst_carry",  32'(carry_o),  0);
        chk("rst_borrow", 32'(borrow_o), 0);
        reset_i = 1'b1;
        tick();
        chk("idle_hold_mode", 32'(mode_o), M_IDLE);

        // ---------------- test 1: carry at +K_ACQ ----------------
        enable_i = 1'b1;
        tick();
        chk("t1_mode_acq", 32'(mode_o), M_ACQ);
        up_i = 1'b1;
        run_count(7, c, b);
        chk("t1_no_carry_7ups", 32'(c), 0);
        tick();
        chk("t1_carry_8th_up", 32'(carry_o), 1);
        tick();                                   // terminal cycle, up ignored
        chk("t1_carry_one_cycle", 32'(carry_o), 0);
        run_count(7, c, b);
        chk("t1_reload_zero_7ups", 32'(c), 0);
        tick();
        chk("t1_reload_zero_8th", 32'(carry_o), 1);
        tick();
        up_i = 1'b0;

        // ---------------- test 2: up&down hold, then borrow ----------------
        up_i   = 1'b1;
        down_i = 1'b1;
        run_count(50, c, b);
        chk("t2_both_no_carry",  32'(c), 0);
        chk("t2_both_no_borrow", 32'(b), 0);
        up_i = 1'b0;
        run_count(7, c, b);
        chk("t2_no_borrow_7downs", 32'(b), 0);
        tick();
        chk("t2_borrow_8th_down", 32'(borrow_o), 1);
        chk("t2_no_carry_on_borrow", 32'(carry_o), 0);
        tick();
        down_i = 1'b0;
        chk("t2_borrow_one_cycle", 32'(borrow_o), 0);

        // ---------------- test 3: lock after 4 quiet windows ----------------
        enable_i = 1'b0;
        tick();
        chk("t3_disable_idle", 32'(mode_o), M_IDLE);
        enable_i = 1'b1;
        tick();
        chk("t3_enter_acq", 32'(mode_o), M_ACQ);
        tick_n(4096);
        chk("t3_still_acq", 32'(mode_o),   M_ACQ);
        chk("t3_not_locked", 32'(locked_o), 0);
        tick();
        chk("t3_track", 32'(mode_o),   M_TRK);
        chk("t3_locked", 32'(locked_o), 1);

        // ---------------- test 4: unlock threshold in TRACK ----------------
        up_i = 1'b1;
        run_count(264, c, b);                      // 8 carries at K=32
        up_i = 1'b0;
        chk("t4_8_carries_k32", 32'(c), 8);
        tick_n(1024 - 264);
        chk("t4_8ev_stays_track", 32'(mode_o), M_TRK);
        up_i = 1'b1;
        run_count(297, c, b);                      // 9 carries in window 2
        up_i = 1'b0;
        chk("t4_9_carries_k32", 32'(c), 9);
        tick_n(1023 - 297);
        chk("t4_track_until_end", 32'(mode_o), M_TRK);
        tick();
        chk("t4_unlock_acq", 32'(mode_o),   M_ACQ);
        chk("t4_unlock_locked", 32'(locked_o), 0);

        // ---------- relock with exactly LOCK_THRESH events per window ----------
        up_i = 1'b1;
        run_count(7, c, b);
        chk("t4_cnt0_7ups", 32'(c), 0);
        tick();
        chk("t4_kacq_carry", 32'(carry_o), 1);
        tick();
        run_count(8, c, b);
        chk("t4_second_carry", 32'(c), 1);
        tick();
        up_i = 1'b0;
        tick_n(4096 - 18);
        chk("t4_relock_wait", 32'(mode_o), M_ACQ);
        tick();
        chk("t4_relock_track", 32'(mode_o), M_TRK);

        // ---------------- test 5: disable from TRACK with cnt=+20 ----------------
        up_i = 1'b1;
        run_count(20, c, b);
        up_i = 1'b0;
        chk("t5_no_carry_20ups", 32'(c), 0);
        enable_i = 1'b0;
        tick();
        chk("t5_idle", 32'(mode_o),   M_IDLE);
        chk("t5_idle_unlocked", 32'(locked_o), 0);
        enable_i = 1'b1;
        tick();
        chk("t5_reacq", 32'(mode_o), M_ACQ);
        up_i = 1'b1;
        run_count(7, c, b);
        chk("t5_cnt_cleared_7ups", 32'(c), 0);
        tick();
        chk("t5_carry_8th", 32'(carry_o), 1);
        tick();

        // ---------------- test 6: async reset with carry pending ----------------
        run_count(8, c, b);
        chk("t6_carry_pending", 32'(carry_o), 1);
        #2;
        reset_i = 1'b0;
        #1;
        chk("t6_rst_carry",  32'(carry_o),  0);
        chk("t6_rst_borrow", 32'(borrow_o), 0);
        chk("t6_rst_mode",   32'(mode_o),   M_IDLE);
        chk("t6_rst_locked", 32'(locked_o), 0);
        reset_i = 1'b1;
        tick();
        chk("t6_post_rst_acq", 32'(mode_o), M_ACQ);
        run_count(7, c, b);
        chk("t6_post_rst_7ups", 32'(c), 0);
        tick();
        chk("t6_post_rst_carry", 32'(carry_o), 1);
        up_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
